fsmc_bus_master: RTL and testbench
==================================

Name: fsmc_bus_master

Overview:
- Initiator side of the STM32 FSMC/FMC asynchronous SRAM-style bus (NE/NOE/NWE/NBL, 20-bit address, 16-bit data) that the LED frontend exposes as a responder.
- Turns single-word read/write commands from a valid/ready interface into correctly timed bus cycles, with programmable address-setup, data-strobe and bus-turnaround phases.
- Serves as the bus model in the frontend testbench and as the master for FPGA-side parallel peripherals (e.g. external SRAM).

Parameters:
ADDSET, 2, address-setup phase length in clk cycles (legal 1..15)
DATAST, 3, data-strobe phase length in clk cycles (legal 1..15)
BUSTURN, 1, turnaround phase with NE high before the next access (legal 1..15)

Ports:
clk  input  1  single clock; all logic rising-edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a clk edge
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  20  word address
cmd_wdata  input  16  write data
cmd_be  input  2  byte enables, active-high; [0] = low byte
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  16  read data, valid with rsp_valid on reads
busy  output  1  high whenever not in IDLE
bus_addr  output  20  address pins a19..a00
bus_ne  output  1  chip select, active-low
bus_noe  output  1  output enable, active-low
bus_nwe  output  1  write enable, active-low
bus_nbl  output  2  byte lanes, active-low (~cmd_be)
bus_dout  output  16  data driven to pad
bus_doe  output  1  pad output enable for bus_dout
bus_din  input  16  data sampled from pad
bus_nwait  input  1  wait from target, active-low (used only with FSMC_NWAIT_EN)

Behaviour:
- All bus_* outputs, cmd_ready, rsp_valid and rsp_rdata are driven directly from flops; no combinational paths from inputs to outputs.
- Reset values: bus_ne=1, bus_noe=1, bus_nwe=1, bus_nbl=2'b11, bus_addr=0, bus_dout=0, bus_doe=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, state=IDLE.
- cmd_ready goes to 1 on the first clk edge after reset deasserts. It is 1 only in IDLE.
- States: IDLE -> SETUP -> DATA -> HOLD -> TURN -> IDLE. A single down-counter loads the phase length on each state entry.
- IDLE:
  - On acceptance, latch the command; cmd_ready=0.
  - Next cycle enter SETUP with bus_ne=0, bus_addr=cmd_addr, bus_nbl=~cmd_be.
  - For writes, bus_dout=cmd_wdata and bus_doe=1 from SETUP onwards.
- SETUP: lasts ADDSET cycles; bus_noe=bus_nwe=1.
- DATA: lasts DATAST cycles; reads drive bus_noe=0, writes drive bus_nwe=0.
  - Reads capture bus_din into rsp_rdata at the clk edge that ends the last DATA cycle.
- HOLD: exactly 1 cycle.
  - bus_noe/bus_nwe return to 1 while bus_ne=0, address and write data are held.
  - The rising NWE edge therefore sees stable data, address and NE.
- TURN: lasts BUSTURN cycles; bus_ne=1, bus_doe=0, bus_nbl=2'b11.
  - rsp_valid=1 for exactly the first TURN cycle, for both reads and writes.
  - rsp_rdata holds its last read value through writes.
- Back-to-back timing: cmd_ready reasserts ADDSET+DATAST+1+BUSTURN cycles after the acceptance edge (7 cycles with defaults).
- Address and data never change while bus_ne=0.
- bus_doe is never 1 during a read or while bus_noe=0.
- cmd_valid in any non-IDLE state is ignored; the command is neither accepted nor dropped, because the requester holds it.
- Reset mid-transaction: outputs return to reset values asynchronously, with NE/NOE/NWE high and the pad released. The transaction is abandoned and no rsp_valid is produced.
- Out-of-range parameters (0 or >15) are caught by an elaboration-time check.

Optional Feature:
- Macro: FSMC_NWAIT_EN.
- When defined:
  - bus_nwait is double-flop synchronised.
  - While the synchronised nwait is 0 during the last DATA cycle, the DATA phase is extended and the strobe stays low.
  - The counter stays at its terminal value until nwait is 1; read data is captured on the edge where DATA ends.
  - After 256 extended cycles, the block forces HOLD and sets rsp_rdata=16'hDEAD for reads.
- When undefined: bus_nwait is ignored and DATA is exactly DATAST cycles.

Test Plan:
- Reset, then idle: all bus controls high, bus_doe=0, cmd_ready rises 1 cycle after reset deasserts, no rsp_valid.
- Write addr=20'h00002, data=16'h00AB, be=2'b11 (defaults): bus_ne low 6 cycles, bus_nwe low 3 cycles, bus_dout=16'h00AB stable from NE fall through the NWE rise, rsp_valid 1 cycle, cmd_ready back after 7 cycles.
- Read addr=20'h00000 with bus_din=16'h000F during DATA: bus_noe low 3 cycles, bus_doe=0 throughout, rsp_rdata=16'h000F with rsp_valid.
- Back-to-back write then read with cmd_valid held: bus_ne high for exactly BUSTURN=1 cycle between accesses, second command accepted in IDLE only.
- Byte write with be=2'b10: bus_nbl=2'b01 during NE low, 2'b11 otherwise.
- Reset asserted mid-DATA of a write: bus_nwe/bus_ne go 1 and bus_doe goes 0 without waiting for clk; no rsp_valid. With FSMC_NWAIT_EN, nwait low for 5 cycles stretches NOE to 3+5+sync latency cycles and the read data captured is the value present at release.

Source files
------------

// File: rtl/fsmc_bus_master.sv
// fsmc_bus_master: initiator for an asynchronous SRAM-style FSMC/FMC bus.
// Accepts single-word read/write commands on a valid/ready interface and plays
// them out as SETUP -> DATA -> HOLD -> TURN bus cycles. Every output is a flop.
// Optional macro FSMC_NWAIT_EN: synchronised bus_nwait stretches the last DATA
// cycle, with a 256-cycle timeout that forces HOLD (reads return 16'hDEAD).

`timescale 1ns / 1ps

module fsmc_bus_master #(
    parameter int unsigned ADDSET  = 2,
    parameter int unsigned DATAST  = 3,
    parameter int unsigned BUSTURN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [19:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [1:0]  cmd_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [19:0] bus_addr,
    output logic        bus_ne,
    output logic        bus_noe,
    output logic        bus_nwe,
    output logic [1:0]  bus_nbl,
    output logic [15:0] bus_dout,
    output logic        bus_doe,
    input  logic [15:0] bus_din,
    input  logic        bus_nwait
);

    // Phase lengths must fit the 4-bit phase counter and be non-zero.
    if (ADDSET < 1 || ADDSET > 15) begin : g_bad_addset
        $error("fsmc_bus_master: ADDSET must be 1..15");
    end
    if (DATAST < 1 || DATAST > 15) begin : g_bad_datast
        $error("fsmc_bus_master: DATAST must be 1..15");
    end
    if (BUSTURN < 1 || BUSTURN > 15) begin : g_bad_busturn
        $error("fsmc_bus_master: BUSTURN must be 1..15");
    end

    localparam logic [3:0] ADDSET_LD  = 4'(ADDSET - 1);
    localparam logic [3:0] DATAST_LD  = 4'(DATAST - 1);
    localparam logic [3:0] BUSTURN_LD = 4'(BUSTURN - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StHold  = 3'd3;
    localparam logic [2:0] StTurn  = 3'd4;

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        r_busy;
    logic [19:0] r_bus_addr;
    logic        r_bus_ne;
    logic        r_bus_noe;
    logic        r_bus_nwe;
    logic [1:0]  r_bus_nbl;
    logic [15:0] r_bus_dout;
    logic        r_bus_doe;

    logic        w_accept;
    logic        w_data_last;
    logic        w_stall;
    logic        w_timeout;

    assign w_accept    = (r_state == StIdle) && r_cmd_ready && cmd_valid;
    assign w_data_last = (r_state == StData) && (r_cnt == 4'd0);

`ifdef FSMC_NWAIT_EN
    logic       r_nwait_s1;
    logic       r_nwait_s2;
    logic [8:0] r_wait_cnt;

    // Two-flop synchroniser for the asynchronous wait input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nwait_s1 <= 1'b1;
            r_nwait_s2 <= 1'b1;
        end else begin
            r_nwait_s1 <= bus_nwait;
            r_nwait_s2 <= r_nwait_s1;
        end
    end

    // Count cycles the last DATA cycle has been stretched by wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 9'd0;
        end else if (w_accept) begin
            r_wait_cnt <= 9'd0;
        end else if (w_stall) begin
            r_wait_cnt <= r_wait_cnt + 9'd1;
        end
    end

    assign w_stall   = w_data_last && !r_nwait_s2 && (r_wait_cnt != 9'd256);
    assign w_timeout = w_data_last && !r_nwait_s2 && (r_wait_cnt == 9'd256);
`else
    logic w_unused_nwait;
    assign w_unused_nwait = bus_nwait;
    assign w_stall        = 1'b0;
    assign w_timeout      = 1'b0;
`endif

    // Bus cycle sequencer; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'h0000;
            r_busy      <= 1'b0;
            r_bus_addr  <= 20'h00000;
            r_bus_ne    <= 1'b1;
            r_bus_noe   <= 1'b1;
            r_bus_nwe   <= 1'b1;
            r_bus_nbl   <= 2'b11;
            r_bus_dout  <= 16'h0000;
            r_bus_doe   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    // Ready rises one edge after reset and stays up until a command lands.
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_write     <= cmd_write;
                        r_state     <= StSetup;
                        r_cnt       <= ADDSET_LD;
                        r_bus_ne    <= 1'b0;
                        r_bus_addr  <= cmd_addr;
                        r_bus_nbl   <= ~cmd_be;
                        if (cmd_write) begin
                            r_bus_dout <= cmd_wdata;
                            r_bus_doe  <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state   <= StData;
                        r_cnt     <= DATAST_LD;
                        r_bus_noe <= r_write;
                        r_bus_nwe <= ~r_write;
                    end
                end
                StData: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!w_stall) begin
                        r_state   <= StHold;
                        r_bus_noe <= 1'b1;
                        r_bus_nwe <= 1'b1;
                        if (!r_write) begin
                            r_rsp_rdata <= w_timeout ? 16'hDEAD : bus_din;
                        end
                    end
                end
                StHold: begin
                    // Strobe is already high; now release chip select and the pad.
                    r_state     <= StTurn;
                    r_cnt       <= BUSTURN_LD;
                    r_bus_ne    <= 1'b1;
                    r_bus_doe   <= 1'b0;
                    r_bus_nbl   <= 2'b11;
                    r_rsp_valid <= 1'b1;
                end
                StTurn: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= StIdle;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;
    assign bus_addr  = r_bus_addr;
    assign bus_ne    = r_bus_ne;
    assign bus_noe   = r_bus_noe;
    assign bus_nwe   = r_bus_nwe;
    assign bus_nbl   = r_bus_nbl;
    assign bus_dout  = r_bus_dout;
    assign bus_doe   = r_bus_doe;

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Testbench for fsmc_bus_master: table of commands played through a per-cycle
// bus timing model, read data scored through an expected-response queue, plus
// hand-written reset sequences.

`timescale 1ns / 1ps

module tb_fsmc_bus_master;

    localparam int unsigned ADDSET  = 2;
    localparam int unsigned DATAST  = 3;
    localparam int unsigned BUSTURN = 1;
    localparam int NE_LOW = ADDSET + DATAST + 1;
    localparam int TOTAL  = NE_LOW + BUSTURN;

    typedef struct {
        logic        write;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] din;
        logic        hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [19:0] bus_addr;
    logic        bus_ne;
    logic        bus_noe;
    logic        bus_nwe;
    logic [1:0]  bus_nbl;
    logic [15:0] bus_dout;
    logic        bus_doe;
    logic [15:0] bus_din;
    logic        bus_nwait;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb_q[$];
    logic [15:0] model_rdata;
    logic [15:0] sb_exp;
    vec_t        vecs[8];

    fsmc_bus_master #(
        .ADDSET (ADDSET),
        .DATAST (DATAST),
        .BUSTURN(BUSTURN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_be   (cmd_be),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .bus_addr (bus_addr),
        .bus_ne   (bus_ne),
        .bus_noe  (bus_noe),
        .bus_nwe  (bus_nwe),
        .bus_nbl  (bus_nbl),
        .bus_dout (bus_dout),
        .bus_doe  (bus_doe),
        .bus_din  (bus_din),
        .bus_nwait(bus_nwait)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest expected read value.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid=1, expected none at %0t", $time);
            end else begin
                sb_exp = sb_q.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(sb_exp));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " ne"},    32'(bus_ne),    32'h1);
        check({tag, " noe"},   32'(bus_noe),   32'h1);
        check({tag, " nwe"},   32'(bus_nwe),   32'h1);
        check({tag, " nbl"},   32'(bus_nbl),   32'h3);
        check({tag, " doe"},   32'(bus_doe),   32'h0);
        check({tag, " ready"}, 32'(cmd_ready), 32'h0);
        check({tag, " rspv"},  32'(rsp_valid), 32'h0);
        check({tag, " busy"},  32'(busy),      32'h0);
    endtask

    // Release reset on a negedge, then ready must appear after exactly one edge.
    task automatic release_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, " ready_pre"}, 32'(cmd_ready), 32'h0);
        @(negedge clk);
        check({tag, " ready_post"}, 32'(cmd_ready), 32'h1);
        check({tag, " busy_post"},  32'(busy),      32'h0);
    endtask

    // Issue one command starting at a negedge and check every bus cycle of it.
    task automatic run_cmd(input vec_t v, input int idx);
        int          wait_cyc;
        logic        in_data;
        logic [1:0]  exp_nbl;
        logic        exp_noe;
        logic        exp_nwe;
        wait_cyc  = 0;
        exp_nbl   = ~v.be;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_be    = v.be;
        cmd_valid = 1'b1;
        bus_din   = ~v.din;
        while (cmd_ready !== 1'b1 && wait_cyc < 32) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (cmd_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL v%0d accept_timeout: got cmd_ready=%b, expected 1", idx, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        if (v.write) begin
            sb_q.push_back(model_rdata);
        end else begin
            sb_q.push_back(v.din);
            model_rdata = v.din;
        end
        @(posedge clk);
        for (int k = 0; k <= TOTAL; k++) begin
            @(negedge clk);
            if (k == 0 && !v.hold) cmd_valid = 1'b0;
            if (k < NE_LOW) begin
                in_data = (k >= int'(ADDSET)) && (k < int'(ADDSET + DATAST));
                exp_noe = !(in_data && !v.write);
                exp_nwe = !(in_data && v.write);
                check($sformatf("v%0d k%0d ne", idx, k),   32'(bus_ne),   32'h0);
                check($sformatf("v%0d k%0d addr", idx, k), 32'(bus_addr), 32'(v.addr));
                check($sformatf("v%0d k%0d nbl", idx, k),  32'(bus_nbl),  32'(exp_nbl));
                check($sformatf("v%0d k%0d doe", idx, k),  32'(bus_doe),  32'(v.write));
                if (v.write) begin
                    check($sformatf("v%0d k%0d dout", idx, k), 32'(bus_dout), 32'(v.wdata));
                end
                check($sformatf("v%0d k%0d noe", idx, k),  32'(bus_noe),   32'(exp_noe));
                check($sformatf("v%0d k%0d nwe", idx, k),  32'(bus_nwe),   32'(exp_nwe));
                check($sformatf("v%0d k%0d rspv", idx, k), 32'(rsp_valid), 32'h0);
                check($sformatf("v%0d k%0d rdy", idx, k),  32'(cmd_ready), 32'h0);
                check($sformatf("v%0d k%0d busy", idx, k), 32'(busy),      32'h1);
            end else if (k < TOTAL) begin
                check($sformatf("v%0d k%0d ne", idx, k),   32'(bus_ne),    32'h1);
                check($sformatf("v%0d k%0d nbl", idx, k),  32'(bus_nbl),   32'h3);
                check($sformatf("v%0d k%0d doe", idx, k),  32'(bus_doe),   32'h0);
                check($sformatf("v%0d k%0d noe", idx, k),  32'(bus_noe),   32'h1);
                check($sformatf("v%0d k%0d nwe", idx, k),  32'(bus_nwe),   32'h1);
                check($sformatf("v%0d k%0d rspv", idx, k), 32'(rsp_valid), 32'(k == NE_LOW));
                check($sformatf("v%0d k%0d rdy", idx, k),  32'(cmd_ready), 32'h0);
                check($sformatf("v%0d k%0d busy", idx, k), 32'(busy),      32'h1);
            end else begin
                // Turnaround over: back in IDLE, ready again.
                check($sformatf("v%0d k%0d ne", idx, k),   32'(bus_ne),    32'h1);
                check($sformatf("v%0d k%0d rspv", idx, k), 32'(rsp_valid), 32'h0);
                check($sformatf("v%0d k%0d rdy", idx, k),  32'(cmd_ready), 32'h1);
                check($sformatf("v%0d k%0d busy", idx, k), 32'(busy),      32'h0);
            end
            // Valid read data only while the strobe is low; anything else is a decoy.
            bus_din = (bus_noe === 1'b0) ? v.din : ~v.din;
        end
    endtask

    initial begin
        int guard;
        vec_t rec_v;
        vecs[0] = '{write: 1'b1, addr: 20'h00002, wdata: 16'h00AB, be: 2'b11, din: 16'h0000, hold: 1'b0};
        vecs[1] = '{write: 1'b0, addr: 20'h00000, wdata: 16'h0000, be: 2'b11, din: 16'h000F, hold: 1'b0};
        vecs[2] = '{write: 1'b1, addr: 20'h00010, wdata: 16'h1234, be: 2'b10, din: 16'h0000, hold: 1'b1};
        vecs[3] = '{write: 1'b0, addr: 20'h00011, wdata: 16'h0000, be: 2'b11, din: 16'hBEEF, hold: 1'b0};
        vecs[4] = '{write: 1'b1, addr: 20'h00003, wdata: 16'h5555, be: 2'b01, din: 16'h0000, hold: 1'b0};
        vecs[5] = '{write: 1'b0, addr: 20'hFFFFF, wdata: 16'h0000, be: 2'b11, din: 16'hA5A5, hold: 1'b1};
        vecs[6] = '{write: 1'b0, addr: 20'h80000, wdata: 16'h0000, be: 2'b00, din: 16'h0000, hold: 1'b0};
        vecs[7] = '{write: 1'b1, addr: 20'hFFFFF, wdata: 16'hFFFF, be: 2'b00, din: 16'h0000, hold: 1'b0};

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 20'h0;
        cmd_wdata   = 16'h0;
        cmd_be      = 2'b00;
        bus_din     = 16'h0;
        bus_nwait   = 1'b1;
        model_rdata = 16'h0000;

        // Reset state while held in reset.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst addr",  32'(bus_addr),  32'h0);
        check("rst dout",  32'(bus_dout),  32'h0);
        check("rst rdata", 32'(rsp_rdata), 32'h0);
        release_reset("rel0");
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], i);
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a write's DATA phase: no clock edge needed to clear.
        cmd_write = 1'b1;
        cmd_addr  = 20'h00044;
        cmd_wdata = 16'hC0DE;
        cmd_be    = 2'b11;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (bus_nwe !== 1'b0 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check("mid nwe_low_seen", 32'(bus_nwe), 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        check("mid rdata", 32'(rsp_rdata), 32'h0);
        sb_q.delete();
        model_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        release_reset("rel1");
        repeat (6) @(negedge clk);

        // Recovery after the abandoned transaction.
        rec_v = '{write: 1'b0, addr: 20'h00123, wdata: 16'h0000, be: 2'b11, din: 16'h3C3C, hold: 1'b0};
        run_cmd(rec_v, 8);
        repeat (4) @(negedge clk);

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
